fp_align_stage: RTL and testbench
=================================

FP_ALIGN_STAGE -- requirements
Module: fp_align_stage

Interface
REQ-001 The module SHALL expose ports: clk  input  1  the single clock; all state updates on its rising edge.
REQ-002 The module SHALL expose ports: rst_n  input  1  reset, synchronous and active-low.
REQ-003 The module SHALL expose ports: in_valid  input  1  operand pair present.
REQ-004 The module SHALL expose ports: in_ready  output  1  stage accepts operands this cycle.
REQ-005 The module SHALL expose ports: a, b  input  32 each  IEEE-754 single-precision operands.
REQ-006 The module SHALL expose ports: operation_select  input  1  selects the operation; ADD_SEL=0, SUB_SEL=1.
REQ-007 The module SHALL expose ports: out_valid  output  1  aligned result held.
REQ-008 The module SHALL expose ports: out_ready  input  1  downstream mantissa adder consumes.
REQ-009 The module SHALL expose ports: big_sign  output  1  sign of the larger-magnitude operand.
REQ-010 The module SHALL expose ports: eff_sub  output  1  effective subtraction.
REQ-011 The module SHALL expose ports: big_exp  output  8  effective exponent of the larger operand.
REQ-012 The module SHALL expose ports: big_mant  output  24  larger mantissa, hidden bit included.
REQ-013 The module SHALL expose ports: small_aligned  output  27  smaller mantissa shifted right, with guard, round and sticky bits in [2:0].
REQ-014 The module SHALL expose ports: is_special  output  1  special-case result valid.
REQ-015 The module SHALL expose ports: special_result  output  32  final word when is_special is 1.

Function
REQ-016 A transfer SHALL occur on a clock edge with in_valid&&in_ready (input) or out_valid&&out_ready (output); latency SHALL be exactly 1 cycle from input transfer to out_valid.
REQ-017 The effective sign of b SHALL be b[31]^operation_select, and eff_sub SHALL be a[31]^(effective sign of b).
REQ-018 The hidden bit SHALL be 1 when exp!=0, else 0, and a denormal SHALL use an effective exponent of 1.
REQ-019 The larger operand SHALL be selected by comparing {exp,mant} unsigned, and on a tie a SHALL be the larger operand.
REQ-020 Alignment: d = big effective exponent minus small effective exponent; small_aligned = {small_mant,3'b0}>>d, with every shifted-out bit ORed into bit 0.
REQ-021 For d>=27, small_aligned SHALL be 27'h1 if small_mant!=0, else 27'h0.
REQ-022 is_special SHALL be 1 when either operand is NaN, or when an infinity is involved in an effective infinity minus infinity, in which case special_result = 32'h7FC00000.
REQ-023 When exactly one operand is infinite, or both are infinite with eff_sub=0, special_result SHALL be infinity carrying the sign of that infinity (using the effective sign for b).
REQ-024 When both operands are zero, special_result SHALL be a zero with sign a[31] AND (effective sign of b).
REQ-025 While out_valid=1 and out_ready=0, all outputs SHALL hold stable and no input SHALL be lost or reordered.
REQ-026 Simultaneous input and output transfers in the same cycle SHALL sustain 1 operation per cycle.

Reset
REQ-027 While rst_n=0 at a clock edge, out_valid SHALL be 0 and is_special SHALL be 0.
REQ-028 While rst_n=0 at a clock edge, all datapath outputs SHALL be 0.
REQ-029 A reset mid-stall SHALL discard held data.
REQ-030 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-031 With FP_ALIGN_SKID_EN defined, a 2-entry skid buffer SHALL make in_ready a registered signal with no combinational path from out_ready, while full throughput SHALL be kept.
REQ-032 With FP_ALIGN_SKID_EN undefined, the stage SHALL be a single register and in_ready = !out_valid || out_ready.

Verification
REQ-033 Stimulus a=32'h3F800000, b=32'h40000000, ADD_SEL with out_ready=1 -> next cycle: out_valid=1, big_exp=8'h80, big_mant=24'h800000, small_aligned=27'h2000000, eff_sub=0, is_special=0.
REQ-034 Stimulus a=32'h7F800000, b=32'h7F800000, SUB_SEL -> is_special=1, special_result=32'h7FC00000.
REQ-035 Stimulus a=32'h3F800000, b=32'h33800000, ADD_SEL -> small_aligned=27'h0000004; with b=32'h30800000 -> small_aligned=27'h0000001.
REQ-036 Stimulus of 3 back-to-back inputs while out_ready=0 for 4 cycles -> outputs frozen on the first input and in_ready=0 when full; all 3 results delivered in order once out_ready=1.
REQ-037 Stimulus of rst_n=0 for one cycle during a stall -> out_valid=0 at the next edge and the held result is never delivered.

Source files
------------

// File: rtl/fp_align_stage.sv
// fp_align_stage: operand alignment stage of a single-precision FP adder.
// Selects the larger-magnitude operand, right-shifts the smaller mantissa
// into a 27-bit guard/round/sticky field and flags special-case results.
// Registered valid/ready stage, one cycle of latency.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake (a, b, operation_select: 0=add, 1=sub)
//   out_valid/out_ready   result handshake to the mantissa adder
//   big_sign, eff_sub     sign of larger operand, effective subtraction
//   big_exp, big_mant     effective exponent / 24-bit mantissa of larger operand
//   small_aligned         smaller mantissa aligned, GRS in [2:0]
//   is_special            special_result holds the final word
//
// Build option: define FP_ALIGN_SKID_EN for a 2-entry skid buffer that
// makes in_ready a flop with no combinational path from out_ready.

package fp_align_stage_pkg;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned MANT_W = FRAC_W + 1;
    localparam int unsigned ALN_W  = MANT_W + 3;
    localparam int unsigned WIDE_W = 2 * ALN_W;

    typedef struct packed {
        logic              big_sign;
        logic              eff_sub;
        logic [EXP_W-1:0]  big_exp;
        logic [MANT_W-1:0] big_mant;
        logic [ALN_W-1:0]  small_aligned;
        logic              is_special;
        logic [WORD_W-1:0] special_result;
    } align_t;
endpackage

module fp_align_stage
    import fp_align_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        operation_select,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        big_sign,
    output logic        eff_sub,
    output logic [7:0]  big_exp,
    output logic [23:0] big_mant,
    output logic [26:0] small_aligned,
    output logic        is_special,
    output logic [31:0] special_result
);

    localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0]  EXP_MAX = '1;

    logic              sign_b;
    logic [EXP_W-1:0]  exp_a, exp_b, eexp_a, eexp_b, eexp_small, shamt;
    logic [FRAC_W-1:0] frac_a, frac_b;
    logic [MANT_W-1:0] mant_a, mant_b, mant_small;
    logic              a_big, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [WIDE_W-1:0] shift_full;
    align_t            calc;
    align_t            out_q;

    // Operand decode, magnitude selection, alignment and special-case detection
    always_comb begin
        sign_b  = b[31] ^ operation_select;
        exp_a   = a[30:23];
        exp_b   = b[30:23];
        frac_a  = a[22:0];
        frac_b  = b[22:0];
        mant_a  = {exp_a != '0, frac_a};
        mant_b  = {exp_b != '0, frac_b};
        // denormals sit at the same scale as exponent 1
        eexp_a  = (exp_a == '0) ? EXP_W'(1) : exp_a;
        eexp_b  = (exp_b == '0) ? EXP_W'(1) : exp_b;
        // {exp,frac} compares as magnitude; a wins ties
        a_big   = a[30:0] >= b[30:0];
        nan_a   = (exp_a == EXP_MAX) && (frac_a != '0);
        nan_b   = (exp_b == EXP_MAX) && (frac_b != '0);
        inf_a   = (exp_a == EXP_MAX) && (frac_a == '0);
        inf_b   = (exp_b == EXP_MAX) && (frac_b == '0);
        zero_a  = a[30:0] == '0;
        zero_b  = b[30:0] == '0;

        calc            = '0;
        calc.eff_sub    = a[31] ^ sign_b;
        calc.big_sign   = a_big ? a[31] : sign_b;
        calc.big_exp    = a_big ? eexp_a : eexp_b;
        calc.big_mant   = a_big ? mant_a : mant_b;
        mant_small      = a_big ? mant_b : mant_a;
        eexp_small      = a_big ? eexp_b : eexp_a;
        shamt           = calc.big_exp - eexp_small;

        // upper half is the aligned value, lower half collects shifted-out bits
        shift_full = {mant_small, 3'b000, ALN_W'(0)} >> shamt;
        if (shamt >= EXP_W'(ALN_W)) begin
            calc.small_aligned = {(ALN_W-1)'(0), |mant_small};
        end else begin
            calc.small_aligned = {shift_full[WIDE_W-1:ALN_W+1],
                                  shift_full[ALN_W] | (|shift_full[ALN_W-1:0])};
        end

        if (nan_a || nan_b || (inf_a && inf_b && calc.eff_sub)) begin
            calc.is_special     = 1'b1;
            calc.special_result = QNAN;
        end else if (inf_a) begin
            calc.is_special     = 1'b1;
            calc.special_result = {a[31], EXP_MAX, FRAC_W'(0)};
        end else if (inf_b) begin
            calc.is_special     = 1'b1;
            calc.special_result = {sign_b, EXP_MAX, FRAC_W'(0)};
        end else if (zero_a && zero_b) begin
            calc.is_special     = 1'b1;
            calc.special_result = {a[31] & sign_b, (WORD_W-1)'(0)};
        end
    end

`ifdef FP_ALIGN_SKID_EN
    logic   skid_valid;
    align_t skid_q;

    // skid_valid is a flop, so in_ready has no path from out_ready
    assign in_ready = !skid_valid;

    // Output register refills from the skid entry first to keep ordering
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_q      <= '0;
            skid_valid <= 1'b0;
            skid_q     <= '0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_q <= calc;
                end
            end
        end else if (in_valid && in_ready) begin
            skid_q     <= calc;
            skid_valid <= 1'b1;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    // Single pipeline register; holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_q <= calc;
            end
        end
    end
`endif

    assign big_sign       = out_q.big_sign;
    assign eff_sub        = out_q.eff_sub;
    assign big_exp        = out_q.big_exp;
    assign big_mant       = out_q.big_mant;
    assign small_aligned  = out_q.small_aligned;
    assign is_special     = out_q.is_special;
    assign special_result = out_q.special_result;

endmodule

// File: tb/tb_fp_align_stage.sv
// tb_fp_align_stage: directed and randomized bench for fp_align_stage with a
// behavioural reference model and an in-order expectation queue.
module tb_fp_align_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        op_sel = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        big_sign, eff_sub, is_special;
    logic [7:0]  big_exp;
    logic [23:0] big_mant;
    logic [26:0] small_aligned;
    logic [31:0] special_result;

    fp_align_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .operation_select(op_sel), .out_valid(out_valid),
        .out_ready(out_ready), .big_sign(big_sign), .eff_sub(eff_sub),
        .big_exp(big_exp), .big_mant(big_mant), .small_aligned(small_aligned),
        .is_special(is_special), .special_result(special_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        op;
    } op_t;

    typedef struct {
        logic        big_sign;
        logic        eff_sub;
        logic [7:0]  big_exp;
        logic [23:0] big_mant;
        logic [26:0] small_aligned;
        logic        is_special;
        logic [31:0] special_result;
    } res_t;

    op_t  inq[$];
    res_t expq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out = 0;
    bit   in_fire_seen = 0;
    bit   rand_ready = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: IEEE field arithmetic done with plain integers
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic op);
        res_t   r;
        int     ex, ey, fx, fy, ebig, esml, d;
        longint mbig, msml, wide, pw, aligned;
        logic   sy, x_big, nanx, nany, infx, infy, zerox, zeroy;
        sy = y[31] ^ op;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        fx = int'(x[22:0]);
        fy = int'(y[22:0]);
        x_big = (x[30:0] >= y[30:0]);
        if (x_big) begin
            ebig = (ex == 0) ? 1 : ex;   mbig = (ex == 0) ? fx : fx + (1 << 23);
            esml = (ey == 0) ? 1 : ey;   msml = (ey == 0) ? fy : fy + (1 << 23);
        end else begin
            ebig = (ey == 0) ? 1 : ey;   mbig = (ey == 0) ? fy : fy + (1 << 23);
            esml = (ex == 0) ? 1 : ex;   msml = (ex == 0) ? fx : fx + (1 << 23);
        end
        r.eff_sub  = x[31] ^ sy;
        r.big_sign = x_big ? x[31] : sy;
        r.big_exp  = 8'(ebig);
        r.big_mant = 24'(mbig);
        d    = ebig - esml;
        wide = msml * 8;
        if (d >= 27) begin
            aligned = (wide != 0) ? 1 : 0;
        end else begin
            pw = 1;
            pw = pw << d;
            aligned = wide / pw;
            if ((wide % pw) != 0) aligned = aligned | 1;
        end
        r.small_aligned = 27'(aligned);
        nanx  = (ex == 255) && (fx != 0);
        nany  = (ey == 255) && (fy != 0);
        infx  = (ex == 255) && (fx == 0);
        infy  = (ey == 255) && (fy == 0);
        zerox = (ex == 0) && (fx == 0);
        zeroy = (ey == 0) && (fy == 0);
        r.is_special = nanx || nany || infx || infy || (zerox && zeroy);
        if (nanx || nany || (infx && infy && r.eff_sub)) r.special_result = 32'h7FC00000;
        else if (infx) r.special_result = {x[31], 8'hFF, 23'd0};
        else if (infy) r.special_result = {sy, 8'hFF, 23'd0};
        else if (zerox && zeroy) r.special_result = {x[31] & sy, 31'd0};
        else r.special_result = 32'd0;
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        int unsigned k = $urandom_range(0, 15);
        logic        s = 1'($urandom_range(0, 1));
        logic [22:0] f = 23'($urandom);
        logic [7:0]  e = 8'($urandom_range(100, 160));
        case (k)
            0: return {s, 31'd0};
            1: return {s, 8'hFF, 23'd0};
            2: return {s, 8'hFF, 23'(f | 23'd1)};
            3: return {s, 8'd0, f};
            4: return {s, 8'($urandom_range(1, 254)), 23'd0};
            default: return {s, e, f};
        endcase
    endfunction

    // Runs at the falling edge: inputs and outputs are stable until the next rising edge
    task automatic monitor();
        res_t r;
        in_fire_seen = 0;
        if (!rst_n) begin
            expq.delete();
            return;
        end
        chk("valid_pending", 32'(out_valid), 32'(expq.size() != 0));
        if (out_valid && expq.size() != 0) begin
            r = expq[0];
            chk("big_sign", 32'(big_sign), 32'(r.big_sign));
            chk("eff_sub", 32'(eff_sub), 32'(r.eff_sub));
            chk("big_exp", 32'(big_exp), 32'(r.big_exp));
            chk("big_mant", 32'(big_mant), 32'(r.big_mant));
            chk("small_aligned", 32'(small_aligned), 32'(r.small_aligned));
            chk("is_special", 32'(is_special), 32'(r.is_special));
            if (r.is_special) chk("special_result", special_result, r.special_result);
            if (out_ready) begin
                expq.delete(0);
                n_out++;
            end
        end
        if (in_valid && in_ready) begin
            expq.push_back(model(a, b, op_sel));
            in_fire_seen = 1;
        end
    endtask

    task automatic present();
        if (inq.size() != 0) begin
            in_valid = 1'b1;
            a = inq[0].x;
            b = inq[0].y;
            op_sel = inq[0].op;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic push_in(input logic [31:0] x, input logic [31:0] y, input logic op);
        op_t t;
        t.x = x; t.y = y; t.op = op;
        inq.push_back(t);
        present();
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (in_fire_seen) inq.delete(0);
        if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
        present();
    endtask

    initial begin
        int k;
        int saved;
        logic [31:0] x, y;

        // reset state
        repeat (3) cycle();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_is_special", 32'(is_special), 0);
        chk("rst_big_exp", 32'(big_exp), 0);
        chk("rst_big_mant", 32'(big_mant), 0);
        chk("rst_small_aligned", 32'(small_aligned), 0);
        chk("rst_special_result", special_result, 0);
        chk("rst_signs", 32'({big_sign, eff_sub}), 0);
        rst_n = 1'b1;
        cycle();
        chk("in_ready_after_rst", 32'(in_ready), 1);

        // 1.0 + 2.0
        out_ready = 1'b1;
        push_in(32'h3F800000, 32'h40000000, 1'b0);
        cycle();
        chk("d1_out_valid", 32'(out_valid), 1);
        chk("d1_big_exp", 32'(big_exp), 32'h80);
        chk("d1_big_mant", 32'(big_mant), 32'h800000);
        chk("d1_small_aligned", 32'(small_aligned), 32'h2000000);
        chk("d1_eff_sub", 32'(eff_sub), 0);
        chk("d1_is_special", 32'(is_special), 0);

        // inf - inf
        push_in(32'h7F800000, 32'h7F800000, 1'b1);
        cycle();
        chk("d2_is_special", 32'(is_special), 1);
        chk("d2_special_result", special_result, 32'h7FC00000);

        // sticky boundaries: d=24 and d=30
        push_in(32'h3F800000, 32'h33800000, 1'b0);
        cycle();
        chk("d3_small_aligned", 32'(small_aligned), 32'h4);
        push_in(32'h3F800000, 32'h30800000, 1'b0);
        cycle();
        chk("d4_small_aligned", 32'(small_aligned), 32'h1);
        cycle();

        // stall with three back-to-back inputs
        out_ready = 1'b0;
        saved = n_out;
        push_in(32'h3F800000, 32'h40000000, 1'b0);
        push_in(32'h40400000, 32'h3F000000, 1'b1);
        push_in(32'hC0A00000, 32'h3E800000, 1'b0);
        repeat (4) begin
            cycle();
            chk("stall_big_mant", 32'(big_mant), 32'h800000);
            chk("stall_small_aligned", 32'(small_aligned), 32'h2000000);
        end
        chk("stall_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        k = 0;
        while ((inq.size() != 0 || expq.size() != 0) && k < 20) begin
            cycle();
            k++;
        end
        chk("stall_delivered", 32'(n_out - saved), 3);

        // reset during a stall discards the held result
        out_ready = 1'b0;
        push_in(32'h41200000, 32'h3F800000, 1'b1);
        k = 0;
        while (inq.size() != 0 && k < 10) begin
            cycle();
            k++;
        end
        chk("held_before_rst", 32'(out_valid), 1);
        saved = n_out;
        rst_n = 1'b0;
        cycle();
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) cycle();
        chk("discarded_not_delivered", 32'(n_out - saved), 0);

        // randomized traffic with random backpressure
        rand_ready = 1;
        for (int i = 0; i < 400; i++) begin
            x = rand_fp();
            y = rand_fp();
            if ($urandom_range(0, 15) == 0) y = {1'($urandom_range(0, 1)), x[30:0]};
            inq.push_back('{x, y, 1'($urandom_range(0, 1))});
        end
        present();
        k = 0;
        while ((inq.size() != 0 || expq.size() != 0) && k < 5000) begin
            cycle();
            k++;
        end
        rand_ready = 0;
        out_ready = 1'b1;
        chk("random_drained", 32'(inq.size() + expq.size()), 0);
        cycle();
        chk("final_idle_valid", 32'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
